// File: rtl/profile_pkg.sv
// Shared opcodes, FSM encoding and STATUS layout for the profiling CI controller.
package profile_pkg;

  localparam int WINDOW_W = 24;

  localparam logic [2:0] OP_READ     = 3'd0;
  localparam logic [2:0] OP_SET_EN   = 3'd1;
  localparam logic [2:0] OP_CLEAR    = 3'd2;
  localparam logic [2:0] OP_WINDOW   = 3'd3;
  localparam logic [2:0] OP_STATUS   = 3'd4;
  localparam logic [2:0] OP_IRQ_MASK = 3'd5;

  localparam int STAT_EN_LSB      = 0;
  localparam int STAT_ACTIVE_BIT  = 4;
  localparam int STAT_EXPIRED_BIT = 5;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_READSEL = 2'd1,
    ST_RESP    = 2'd2
  } state_t;

  function automatic logic [31:0] status_word(input logic       expired,
                                              input logic       active,
                                              input logic [3:0] en);
    logic [31:0] w;
    w = '0;
    w[STAT_EN_LSB +: 4]    = en;
    w[STAT_ACTIVE_BIT]     = active;
    w[STAT_EXPIRED_BIT]    = expired;
    return w;
  endfunction

endpackage

// File: rtl/profile_ci_ctrl_if.sv
// CPU custom-instruction bus: CPU side drives the command, controller returns done/result.
interface profile_ci_ctrl_if;
  logic        start;
  logic [7:0]  ciN;
  logic [31:0] valueA;
  logic [31:0] valueB;
  logic        done;
  logic [31:0] result;

  modport master (output start, ciN, valueA, valueB, input done, result);
  modport slave  (input start, ciN, valueA, valueB, output done, result);
endinterface

// File: rtl/profile_window_timer.sv
// Measurement window down-counter: load N, count down while active, expire pulse on the last cycle.
// Load has priority over cancel; expire is combinational from the registered count.
module profile_window_timer
  import profile_pkg::*;
(
  input  logic                clock,
  input  logic                reset,
  input  logic                load,
  input  logic [WINDOW_W-1:0] load_val,
  input  logic                cancel,
  output logic                active,
  output logic                expire
);

  logic [WINDOW_W-1:0] cnt_q, cnt_d;
  logic                active_q, active_d;

  assign active = active_q;
  assign expire = active_q && (cnt_q == WINDOW_W'(1));

  always_comb begin
    cnt_d    = cnt_q;
    active_d = active_q;
    if (load) begin
      cnt_d    = load_val;
      active_d = (load_val != '0);
    end else if (cancel) begin
      active_d = 1'b0;
    end else if (active_q) begin
      cnt_d = cnt_q - WINDOW_W'(1);
      if (expire) active_d = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q    <= '0;
      active_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      active_q <= active_d;
    end
  end

endmodule

// File: rtl/profile_ci_ctrl.sv
// Profiling CI controller: decodes CI commands into counter enable/clear/select, with auto-stop window.
// PROFILE_CTRL_IRQ_EN adds an irq output and a mask written by opcode 5.
module profile_ci_ctrl
  import profile_pkg::*;
#(
  parameter logic [7:0] customId    = 8'd9,
  parameter int         NR_COUNTERS = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  profile_ci_ctrl_if.slave       ci,
  output logic [NR_COUNTERS-1:0] cntEnable,
  output logic [NR_COUNTERS-1:0] cntClear,
  output logic [1:0]             cntSel,
  input  logic [31:0]            cntValue
`ifdef PROFILE_CTRL_IRQ_EN
  ,
  output logic                   irq
`endif
);

  state_t                 state_q, state_d;
  logic                   done_q, done_d;
  logic [31:0]            result_q, result_d;
  logic [NR_COUNTERS-1:0] en_q, en_d;
  logic [NR_COUNTERS-1:0] clr_q, clr_d;
  logic [1:0]             sel_q, sel_d;
  logic                   expired_q, expired_d;
  logic                   stat_resp_q, stat_resp_d;

  logic [2:0] opcode;
  logic       accept, cmd_wins, expire_set;
  logic       win_active, win_expire;
  logic       unused_bits;

  assign opcode      = ci.valueA[2:0];
  assign accept      = ci.start && (ci.ciN == customId) && (state_q == ST_IDLE);
  assign cmd_wins    = accept && ((opcode == OP_SET_EN) || (opcode == OP_WINDOW));
  assign expire_set  = win_expire && !cmd_wins;
  assign unused_bits = ^{ci.valueA[7:3], ci.valueB[31:NR_COUNTERS]};

  profile_window_timer u_timer (
    .clock    (clock),
    .reset    (reset),
    .load     (accept && (opcode == OP_WINDOW)),
    .load_val (ci.valueA[31:8]),
    .cancel   (accept && (opcode == OP_SET_EN)),
    .active   (win_active),
    .expire   (win_expire)
  );

  always_comb begin
    state_d     = state_q;
    done_d      = 1'b0;
    result_d    = result_q;
    en_d        = expire_set ? '0 : en_q;
    clr_d       = '0;
    sel_d       = sel_q;
    expired_d   = expired_q;
    stat_resp_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          result_d    = '0;
          stat_resp_d = (opcode == OP_STATUS);
          if (opcode == OP_READ) begin
            state_d = ST_READSEL;
          end else begin
            state_d = ST_RESP;
            done_d  = 1'b1;
          end
          case (opcode)
            OP_READ:   sel_d    = ci.valueB[1:0];
            OP_SET_EN: en_d     = ci.valueB[NR_COUNTERS-1:0];
            OP_CLEAR:  clr_d    = ci.valueB[NR_COUNTERS-1:0];
            OP_WINDOW: en_d     = ci.valueB[NR_COUNTERS-1:0];
            OP_STATUS: result_d = status_word(expired_q, win_active, en_q);
            default: ;
          endcase
        end
      end
      ST_READSEL: begin
        result_d = cntValue;
        done_d   = 1'b1;
        state_d  = ST_RESP;
      end
      ST_RESP: begin
        result_d = '0;
        state_d  = ST_IDLE;
        if (stat_resp_q) expired_d = 1'b0;
      end
      default: state_d = ST_IDLE;
    endcase
    // A fresh expiry outranks the STATUS read-clear so the event is never lost.
    if (expire_set) expired_d = 1'b1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      done_q      <= 1'b0;
      result_q    <= '0;
      en_q        <= '0;
      clr_q       <= '0;
      sel_q       <= '0;
      expired_q   <= 1'b0;
      stat_resp_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      done_q      <= done_d;
      result_q    <= result_d;
      en_q        <= en_d;
      clr_q       <= clr_d;
      sel_q       <= sel_d;
      expired_q   <= expired_d;
      stat_resp_q <= stat_resp_d;
    end
  end

  assign ci.done   = done_q;
  assign ci.result = result_q;
  assign cntEnable = en_q;
  assign cntClear  = clr_q;
  assign cntSel    = sel_q;

`ifdef PROFILE_CTRL_IRQ_EN
  logic irq_mask_q, irq_mask_d;
  logic irq_q, irq_d;

  always_comb begin
    irq_mask_d = irq_mask_q;
    if (accept && (opcode == OP_IRQ_MASK)) irq_mask_d = ci.valueB[0];
    irq_d = expire_set && irq_mask_q;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      irq_mask_q <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      irq_mask_q <= irq_mask_d;
      irq_q      <= irq_d;
    end
  end

  assign irq = irq_q;
`endif

endmodule

// File: tb/tb_profile_ci_ctrl.sv
// Bench for profile_ci_ctrl: fixed vector table, hand-written window/reset sequences,
// then random commands against a cycle-level model of the command and window rules.
module tb_profile_ci_ctrl;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  cntEnable, cntClear;
  logic [1:0]  cntSel;
  logic [31:0] cntValue;
  logic [31:0] bank [4];

  int vectors     = 0;
  int miscompares = 0;

  profile_ci_ctrl_if ci ();

  profile_ci_ctrl dut (
    .clock     (clock),
    .reset     (reset),
    .ci        (ci),
    .cntEnable (cntEnable),
    .cntClear  (cntClear),
    .cntSel    (cntSel),
    .cntValue  (cntValue)
  );

  assign cntValue = bank[cntSel];

  always #5 clock = ~clock;

  // Reference model: command in flight counted in cycles left, window as cycles of enable left.
  int          m_busy;
  bit          m_stat;
  logic [3:0]  m_en, m_clr;
  logic [1:0]  m_sel;
  bit          m_expired;
  int          m_left;
  logic        m_done;
  logic [31:0] m_res;

  task automatic model_reset();
    m_busy = 0; m_stat = 0; m_en = 0; m_clr = 0; m_sel = 0;
    m_expired = 0; m_left = 0; m_done = 0; m_res = 0;
  endtask

  task automatic model_step();
    logic [3:0] en0;
    bit         exp0, acc, cmd_wins;
    int         left0;
    logic [2:0] op;
    en0 = m_en; exp0 = m_expired; left0 = m_left;
    op = ci.valueA[2:0];
    acc = ci.start && (ci.ciN == 8'd9) && (m_busy == 0);
    cmd_wins = acc && (op == 3'd1 || op == 3'd3);
    m_done = 0; m_res = 0; m_clr = 0;
    if (m_busy == 2) begin
      m_busy = 1; m_done = 1; m_res = bank[m_sel];
    end else if (m_busy == 1) begin
      m_busy = 0;
      if (m_stat) m_expired = 0;
      m_stat = 0;
    end else if (acc) begin
      if (op == 3'd0) begin
        m_sel = ci.valueB[1:0]; m_busy = 2;
      end else begin
        m_busy = 1; m_done = 1; m_stat = (op == 3'd4);
        case (op)
          3'd1: begin m_en = ci.valueB[3:0]; m_left = 0; end
          3'd2: m_clr = ci.valueB[3:0];
          3'd3: begin m_en = ci.valueB[3:0]; m_left = int'(ci.valueA[31:8]); end
          3'd4: m_res = {26'd0, exp0, (left0 > 0), en0};
          default: ;
        endcase
      end
    end
    if (!cmd_wins && left0 > 0) begin
      m_left = left0 - 1;
      if (m_left == 0) begin
        m_en = 4'd0; m_expired = 1;
      end
    end
  endtask

  task automatic tick();
    @(posedge clock);
    if (!reset) model_reset();
    else model_step();
    @(negedge clock);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic st, input logic [7:0] n, input logic [31:0] a, input logic [31:0] b);
    ci.start = st; ci.ciN = n; ci.valueA = a; ci.valueB = b;
  endtask

  task automatic idle();
    drive(1'b0, 8'd0, 32'd0, 32'd0);
  endtask

  typedef struct {
    logic        start;
    logic [7:0]  ci_n;
    logic [31:0] va, vb;
    logic        done;
    logic [31:0] res;
    logic [3:0]  en, clr;
    logic [1:0]  sel;
  } vec_t;

  vec_t tbl[15];

  initial begin
    int on_cycles;
    bank[0] = 32'h11111111; bank[1] = 32'h22222222;
    bank[2] = 32'hDEADBEEF; bank[3] = 32'h44444444;
    idle();
    model_reset();

    //        start ciN    valueA  valueB  done result        en    clr   sel
    tbl[0]  = '{1'b1, 8'd9, 32'd1, 32'd3,  1'b1, 32'h0,        4'h3, 4'h0, 2'd0};
    tbl[1]  = '{1'b0, 8'd0, 32'd0, 32'd0,  1'b0, 32'h0,        4'h3, 4'h0, 2'd0};
    tbl[2]  = '{1'b1, 8'd9, 32'd0, 32'd2,  1'b0, 32'h0,        4'h3, 4'h0, 2'd2};
    tbl[3]  = '{1'b0, 8'd0, 32'd0, 32'd0,  1'b1, 32'hDEADBEEF, 4'h3, 4'h0, 2'd2};
    tbl[4]  = '{1'b0, 8'd0, 32'd0, 32'd0,  1'b0, 32'h0,        4'h3, 4'h0, 2'd2};
    tbl[5]  = '{1'b1, 8'd9, 32'd2, 32'd5,  1'b1, 32'h0,        4'h3, 4'h5, 2'd2};
    tbl[6]  = '{1'b0, 8'd0, 32'd0, 32'd0,  1'b0, 32'h0,        4'h3, 4'h0, 2'd2};
    tbl[7]  = '{1'b1, 8'd8, 32'd1, 32'hF,  1'b0, 32'h0,        4'h3, 4'h0, 2'd2};
    tbl[8]  = '{1'b0, 8'd0, 32'd0, 32'd0,  1'b0, 32'h0,        4'h3, 4'h0, 2'd2};
    tbl[9]  = '{1'b1, 8'd9, 32'd1, 32'd1,  1'b1, 32'h0,        4'h1, 4'h0, 2'd2};
    tbl[10] = '{1'b1, 8'd9, 32'd1, 32'hF,  1'b0, 32'h0,        4'h1, 4'h0, 2'd2};
    tbl[11] = '{1'b1, 8'd9, 32'd4, 32'd0,  1'b1, 32'h1,        4'h1, 4'h0, 2'd2};
    tbl[12] = '{1'b0, 8'd0, 32'd0, 32'd0,  1'b0, 32'h0,        4'h1, 4'h0, 2'd2};
    tbl[13] = '{1'b1, 8'd9, 32'd7, 32'hF,  1'b1, 32'h0,        4'h1, 4'h0, 2'd2};
    tbl[14] = '{1'b0, 8'd0, 32'd0, 32'd0,  1'b0, 32'h0,        4'h1, 4'h0, 2'd2};

    // Reset state
    tick(); tick();
    check("rst_done", 32'(ci.done), 32'd0);
    check("rst_result", ci.result, 32'd0);
    check("rst_en", 32'(cntEnable), 32'd0);
    check("rst_clr", 32'(cntClear), 32'd0);
    check("rst_sel", 32'(cntSel), 32'd0);
    reset = 1'b1;

    for (int i = 0; i < 15; i++) begin
      drive(tbl[i].start, tbl[i].ci_n, tbl[i].va, tbl[i].vb);
      tick();
      check($sformatf("tbl%0d_done", i), 32'(ci.done), 32'(tbl[i].done));
      check($sformatf("tbl%0d_result", i), ci.result, tbl[i].res);
      check($sformatf("tbl%0d_en", i), 32'(cntEnable), 32'(tbl[i].en));
      check($sformatf("tbl%0d_clr", i), 32'(cntClear), 32'(tbl[i].clr));
      check($sformatf("tbl%0d_sel", i), 32'(cntSel), 32'(tbl[i].sel));
    end
    idle();

    // Window of 10 cycles, then STATUS twice
    drive(1'b1, 8'd9, {24'd10, 5'd0, 3'd3}, 32'hF);
    on_cycles = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      idle();
      if (cntEnable == 4'hF) on_cycles++;
    end
    check("win10_on_cycles", 32'(on_cycles), 32'd10);
    check("win10_en_after", 32'(cntEnable), 32'd0);
    drive(1'b1, 8'd9, 32'd4, 32'd0);
    tick(); idle();
    check("status1_done", 32'(ci.done), 32'd1);
    check("status1_result", ci.result, 32'h20);
    tick();
    drive(1'b1, 8'd9, 32'd4, 32'd0);
    tick(); idle();
    check("status2_done", 32'(ci.done), 32'd1);
    check("status2_result", ci.result, 32'h0);
    tick();

    // Window of 5 with SET_EN landing on the expiry cycle
    drive(1'b1, 8'd9, {24'd5, 5'd0, 3'd3}, 32'hF);
    tick(); idle();
    for (int i = 0; i < 4; i++) tick();
    check("win5_en_last", 32'(cntEnable), 32'hF);
    drive(1'b1, 8'd9, 32'd1, 32'd1);
    tick(); idle();
    check("race_en", 32'(cntEnable), 32'h1);
    for (int i = 0; i < 4; i++) tick();
    check("race_en_hold", 32'(cntEnable), 32'h1);
    drive(1'b1, 8'd9, 32'd4, 32'd0);
    tick(); idle();
    check("race_status", ci.result, 32'h1);
    tick();

    // Reset during READSEL
    drive(1'b1, 8'd9, 32'd0, 32'd2);
    tick(); idle();
    check("abort_sel", 32'(cntSel), 32'd2);
    #2 reset = 1'b0;
    #1;
    check("abort_done", 32'(ci.done), 32'd0);
    check("abort_result", ci.result, 32'd0);
    check("abort_en", 32'(cntEnable), 32'd0);
    check("abort_clr", 32'(cntClear), 32'd0);
    check("abort_sel0", 32'(cntSel), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("abort_no_done", 32'(ci.done), 32'd0);
    end
    reset = 1'b1;
    drive(1'b1, 8'd9, 32'd0, 32'd2);
    tick(); idle();
    check("read2_c1_done", 32'(ci.done), 32'd0);
    check("read2_c1_sel", 32'(cntSel), 32'd2);
    tick();
    check("read2_c2_done", 32'(ci.done), 32'd1);
    check("read2_c2_result", ci.result, 32'hDEADBEEF);
    tick();
    check("read2_c3_done", 32'(ci.done), 32'd0);
    check("read2_c3_result", ci.result, 32'd0);

    // Random commands against the model
    for (int i = 0; i < 3000; i++) begin
      logic [2:0] op;
      op = 3'($urandom_range(7));
      for (int b = 0; b < 4; b++) bank[b] = $urandom;
      drive(($urandom_range(2) == 0), ($urandom_range(7) == 0) ? 8'd8 : 8'd9,
            {24'($urandom_range(12)), 5'($urandom), op}, $urandom);
      tick();
      check("rnd_done", 32'(ci.done), 32'(m_done));
      check("rnd_result", ci.result, m_res);
      check("rnd_en", 32'(cntEnable), 32'(m_en));
      check("rnd_clr", 32'(cntClear), 32'(m_clr));
      check("rnd_sel", 32'(cntSel), 32'(m_sel));
    end
    idle();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/profile_ci_ctrl.md
Name: profile_ci_ctrl

Overview:
Multi-cycle custom-instruction controller that sequences the four-counter profiling bank (cycle, stall, busIdle, cycle-2).
- Decodes CPU CI commands and drives per-counter enable/clear lines.
- Provides an auto-stopping measurement window of N cycles.
- Registers counter readback and status into the CI result.
- Sits between the CPU CI bus and the counter bank; the bank holds only counters and a read mux.

Parameters:
customId, 8'd9, CI number this block answers to
NR_COUNTERS, 4, counters in the bank (fixed at 4 in this revision)

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-low reset
start  in  1  CI start strobe from CPU
ciN  in  8  CI number
valueA  in  32  command word; [2:0] opcode
valueB  in  32  command operand
done  out  1  CI completion, one-cycle pulse
result  out  32  CI result, valid only while done=1, else 0
cntEnable  out  4  per-counter count enable to bank
cntClear  out  4  per-counter synchronous clear to bank, one-cycle pulse
cntSel  out  2  bank readback select
cntValue  in  32  bank readback value, combinational from cntSel

Behaviour:
- Reset (reset=0, asynchronous):
  - done=0, result=0, cntEnable=0, cntClear=0, cntSel=0.
  - Window counter=0, windowActive=0, expired flag=0, FSM=IDLE.
- Accept rule: accept = start && ciN==customId && FSM==IDLE. A start in any other state is ignored.
- FSM states: IDLE, READSEL, RESP.
  - IDLE + accept, opcode READ -> READSEL.
  - IDLE + accept, any other opcode -> RESP.
  - READSEL -> RESP.
  - RESP -> IDLE.
- done=1 for exactly the RESP cycle.
  - Latency from accepting edge: READ = 2 cycles; all other opcodes = 1 cycle.
- Opcodes (valueA[2:0]):
  - 0 READ: cntSel<=valueB[1:0] at accept. In READSEL, cntValue is captured into the result register. result is presented in RESP.
  - 1 SET_EN: cntEnable<=valueB[3:0]. Cancels any window: windowActive<=0. result=0.
  - 2 CLEAR: cntClear=valueB[3:0] for the one cycle after accept. cntEnable is unchanged. result=0.
  - 3 WINDOW: cntEnable<=valueB[3:0]; window counter<=valueA[31:8] (24-bit N); windowActive<=(N!=0). result=0.
    - N=0 behaves as SET_EN (free-running).
  - 4 STATUS: result={26'b0, expired, windowActive, cntEnable}. expired is cleared in the RESP cycle.
  - 5..7: reserved. done still pulses after 1 cycle with result=0 and no side effects.
- Window timing:
  - While windowActive, the window counter decrements every cycle.
  - On the cycle it reaches 1: cntEnable<=0 at the next edge, windowActive<=0, expired<=1.
  - Net effect: counters enabled exactly N cycles.
- Simultaneous events:
  - Window expiry in the same cycle as an accepted SET_EN or WINDOW: the command wins; expired is not set.
  - Expiry during READSEL or RESP proceeds normally.
- Saturation: none; the counters wrap in the bank.
- Reset mid-command: the FSM returns to IDLE immediately, and no done is issued for the aborted command.

Optional Feature:
PROFILE_CTRL_IRQ_EN
- Defined: adds output port irq (1 bit).
  - irq pulses high for one cycle on the cycle expired is set.
  - An irqMask bit is added, written by opcode 5 (valueB[0]). It resets to 0 (masked).
  - irq is gated by irqMask.
- Undefined: no irq port; opcode 5 is reserved.

Decomposition:
- Shared package profile_pkg holds:
  - opcode localparams: OP_READ, OP_SET_EN, OP_CLEAR, OP_WINDOW, OP_STATUS, OP_IRQ_MASK
  - FSM state encoding
  - STATUS bit positions
  - WINDOW_W=24
- One natural sub-module, profile_window_timer: load / decrement / expire-pulse logic with cancel input.

Test Plan:
1. Reset release, then SET_EN valueB=4'b0011 -> done 1 cycle after start; cntEnable=0011; result=0.
2. WINDOW, valueA={24'd10,5'b0,3'd3}, valueB=4'b1111 -> cntEnable=1111 for exactly 10 cycles, then 0. STATUS then returns 32'h20; a second STATUS returns 32'h0.
3. READ valueB=2 with bank value 32'hDEADBEEF -> cntSel=2 from cycle 1; done on cycle 2; result=32'hDEADBEEF; result=0 on the cycle after.
4. CLEAR valueB=4'b0101 -> cntClear=0101 for one cycle, cntEnable unchanged. A wrong ciN (8'd8) gives no done and no effect.
5. WINDOW N=5, then SET_EN 4'b0001 issued on the expiry cycle -> cntEnable=0001 and stays; STATUS expired bit=0.
6. Assert reset low during READSEL -> done never pulses; all outputs 0 asynchronously. A new READ after release completes normally.
